mac_dot_seq_ctrl: RTL

//   Sequencer for one mac_uint8_int32 unit: on a start command it streams LEN
//   (data,weight) byte pairs from two sync-read memories into the MAC, drives

---
 rtl/mac_dot_seq_ctrl_if.sv | 55 +++++
 rtl/mac_dot_seq_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mac_dot_seq_ctrl_if.sv
// Bus bundle between the dot-product sequencer and its environment:
// command/handshake, the two sync-read memories, the MAC unit and the
// result handshake. "master" is the sequencer side, "slave" is the side
// that owns the memories, the MAC and the command/result endpoints.
interface mac_dot_seq_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 10
);
  // command
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] data_base;
  logic [ADDR_W-1:0] weight_base;
  logic              abort;
  logic              busy;
  // memories
  logic              data_rd;
  logic [ADDR_W-1:0] data_addr;
  logic [7:0]        data_rdata;
  logic              weight_rd;
  logic [ADDR_W-1:0] weight_addr;
  logic [7:0]        weight_rdata;
  // MAC unit
  logic [7:0]        mac_data;
  logic [7:0]        mac_weight;
  logic              mac_enable;
  logic              mac_clear;
  logic [31:0]       mac_acc;
  // result
  logic [31:0]       result_data;
  logic              result_valid;
  logic              result_ready;

  modport master (
    input  start, len, data_base, weight_base, abort,
    output busy,
    output data_rd, data_addr, weight_rd, weight_addr,
    input  data_rdata, weight_rdata,
    output mac_data, mac_weight, mac_enable, mac_clear,
    input  mac_acc,
    output result_data, result_valid,
    input  result_ready
  );

  modport slave (
    output start, len, data_base, weight_base, abort,
    input  busy,
    input  data_rd, data_addr, weight_rd, weight_addr,
    output data_rdata, weight_rdata,
    input  mac_data, mac_weight, mac_enable, mac_clear,
    output mac_acc,
    input  result_data, result_valid,
    output result_ready
  );
endinterface

// File: rtl/mac_dot_seq_ctrl.sv
// Dot-product sequencer for one uint8 x uint8 -> int32 MAC unit.
// A start command streams len (data, weight) byte pairs from two
// sync-read memories into the MAC, then hands the accumulated 32-bit
// result to the consumer over a valid/ready handshake.
module mac_dot_seq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 10
) (
  input  logic                 clock,
  input  logic                 reset,   // asynchronous, active low
  mac_dot_seq_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;   // next element offset to read
  logic [LEN_W-1:0]  en_cnt;      // enable cycles already spent in RUN
  logic [ADDR_W-1:0] data_base_q;
  logic [ADDR_W-1:0] weight_base_q;
  logic [31:0]       result_q;
  logic              rd;
  logic [LEN_W-1:0]  offset;
  logic              accept;

  // A command is taken only from IDLE; abort on the same cycle wins.
  assign accept = (state == S_IDLE) && bus.start && !bus.abort;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default at the top of a combinational block guarantees every
  // path assigns the variable, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = (bus.len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nxt = bus.abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.abort)                           state_nxt = S_IDLE;
        else if (en_cnt == len_q - LEN_W'(1))    state_nxt = S_WAIT;
      end
      S_WAIT:  state_nxt = bus.abort ? S_IDLE : S_DONE;
      S_DONE:  if (bus.result_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory read strobe and element offset: element 0 in CLEAR, the rest
  // in RUN while elements remain to be issued.
  always_comb begin
    rd     = 1'b0;
    offset = '0;
    unique case (state)
      S_CLEAR: rd = 1'b1;
      S_RUN: begin
        rd     = (issue_cnt < len_q);
        offset = issue_cnt;
      end
      default: ;
    endcase
  end

  // Command latch, issue/enable counters and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q         <= '0;
      data_base_q   <= '0;
      weight_base_q <= '0;
      issue_cnt     <= '0;
      en_cnt        <= '0;
      result_q      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            len_q         <= bus.len;
            data_base_q   <= bus.data_base;
            weight_base_q <= bus.weight_base;
            // Element 0 is read in CLEAR, so RUN continues from offset 1.
            issue_cnt     <= LEN_W'(1);
            en_cnt        <= '0;
            if (bus.len == '0) result_q <= '0;
          end
        end
        S_RUN: begin
          if (rd) issue_cnt <= issue_cnt + LEN_W'(1);
          en_cnt <= en_cnt + LEN_W'(1);
        end
        // The MAC accumulator is registered: the last enabled sample has
        // landed by the time WAIT is active.
        S_WAIT: if (!bus.abort) result_q <= bus.mac_acc;
        default: ;
      endcase
    end
  end

  // Addresses are driven only while reading and wrap modulo 2**ADDR_W.
  assign bus.data_rd      = rd;
  assign bus.weight_rd    = rd;
  assign bus.data_addr    = rd ? data_base_q   + ADDR_W'(offset) : '0;
  assign bus.weight_addr  = rd ? weight_base_q + ADDR_W'(offset) : '0;

  assign bus.mac_data     = bus.data_rdata;
  assign bus.mac_weight   = bus.weight_rdata;
  assign bus.mac_enable   = (state == S_RUN);
  assign bus.mac_clear    = (state == S_CLEAR);

  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = (state == S_DONE);
  assign bus.result_data  = result_q;

endmodule
